// File: rtl/cic_decim_pkg.sv
// Shared types and elaboration-time helpers for the CIC decimator.
package cic_decim_pkg;

  // Bit positions within out_error.
  typedef enum logic [0:0] {
    ErrUpstream = 1'b0,
    ErrSequence = 1'b1
  } cic_err_bit_e;

  // ceil(log2((rate*m)**n)); the product can exceed 64 bits at the top of the parameter range.
  function automatic int unsigned cic_growth(int unsigned rate, int unsigned m, int unsigned n);
    logic [127:0] prod;
    int unsigned  g;
    prod = 128'd1;
    for (int unsigned i = 0; i < n; i++) prod = prod * 128'(rate * m);
    g = 0;
    while ((128'd1 << g) < prod) g++;
    return g;
  endfunction

  function automatic int unsigned cic_ch_w(int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int unsigned DefW    = 16 + cic_growth(125, 1, 4);
  localparam int unsigned DefChW  = cic_ch_w(2);

endpackage

// File: rtl/cic_decim_if.sv
// Avalon-ST sink and source bundle of the CIC decimator.
interface cic_decim_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH_W  = 1
) ();
  logic [IN_W-1:0]  in_data;
  logic [CH_W-1:0]  in_channel;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_error;
  logic             in_startofpacket;
  logic             in_endofpacket;
  logic [OUT_W-1:0] out_data;
  logic [CH_W-1:0]  out_channel;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_error;
  logic             out_startofpacket;
  logic             out_endofpacket;

  modport slave (
    input  in_data, in_channel, in_valid, in_error, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_data, out_channel, out_valid, out_error, out_startofpacket,
           out_endofpacket
  );

  modport master (
    output in_data, in_channel, in_valid, in_error, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_data, out_channel, out_valid, out_error, out_startofpacket,
           out_endofpacket
  );
endinterface

// File: rtl/cic_comb_chain.sv
// Comb section over one channel's delay slice: y = x - x[n-M] per stage, plus the shifted delays.
module cic_comb_chain #(
  parameter int unsigned W          = 44,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned DIFF_DELAY = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] dly      [STAGES*DIFF_DELAY],
  output logic [W-1:0] y,
  output logic [W-1:0] dly_next [STAGES*DIFF_DELAY]
);
  always_comb begin
    logic [W-1:0] stage_in;
    stage_in = x;
    for (int s = 0; s < STAGES; s++) begin
      dly_next[s*DIFF_DELAY] = stage_in;
      for (int j = 1; j < DIFF_DELAY; j++) dly_next[s*DIFF_DELAY+j] = dly[s*DIFF_DELAY+j-1];
      stage_in = stage_in - dly[s*DIFF_DELAY+DIFF_DELAY-1];
    end
    y = stage_in;
  end
endmodule

// File: rtl/cic_decim.sv
// Multi-channel CIC decimator with Avalon-ST ports and backpressure.
// Define CIC_DECIM_ROUND_EN for round-half-up with saturation instead of truncation.
module cic_decim
  import cic_decim_pkg::*;
#(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned RATE       = 125,
  parameter int unsigned DIFF_DELAY = 1,
  parameter int unsigned CHANNELS   = 2
) (
  input logic        clk,
  input logic        reset_n,
  cic_decim_if.slave bus
);
  localparam int unsigned W     = IN_W + cic_growth(RATE, DIFF_DELAY, STAGES);
  localparam int unsigned CH_W  = cic_ch_w(CHANNELS);
  localparam int unsigned PH_W  = $clog2(RATE);
  localparam int unsigned DLY_N = STAGES * DIFF_DELAY;

  logic [W-1:0]     integ_q [CHANNELS][STAGES];
  logic [W-1:0]     dly_q   [CHANNELS][DLY_N];
  logic [PH_W-1:0]  phase_q [CHANNELS];
  logic [1:0]       err_q   [CHANNELS];
  logic [CH_W-1:0]  exp_ch_q;
  logic             out_valid_q, out_sop_q, out_eop_q;
  logic [OUT_W-1:0] out_data_q;
  logic [CH_W-1:0]  out_channel_q;
  logic [1:0]       out_error_q;

  logic             accept, seq_ok, beat, dump;
  logic [CH_W-1:0]  ch;
  logic [W-1:0]     integ_new [STAGES];
  logic [W-1:0]     dly_sel   [DLY_N];
  logic [W-1:0]     dly_new   [DLY_N];
  logic [W-1:0]     comb_res;
  logic [OUT_W-1:0] out_slice;
  logic             unused_eop;

  assign unused_eop   = bus.in_endofpacket;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // SOP resynchronises the stream onto channel 0 regardless of in_channel.
  assign ch           = bus.in_startofpacket ? '0 : bus.in_channel;
  assign seq_ok       = bus.in_startofpacket || (bus.in_channel == exp_ch_q);
  assign beat         = accept && seq_ok;
  assign dump         = beat && (phase_q[ch] == PH_W'(RATE - 1));

  always_comb begin
    integ_new[0] = integ_q[ch][0] + {{(W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    for (int k = 1; k < STAGES; k++) integ_new[k] = integ_q[ch][k] + integ_new[k-1];
    for (int i = 0; i < DLY_N; i++) dly_sel[i] = dly_q[ch][i];
  end

  cic_comb_chain #(
    .W          (W),
    .STAGES     (STAGES),
    .DIFF_DELAY (DIFF_DELAY)
  ) u_comb (
    .x        (integ_new[STAGES-1]),
    .dly      (dly_sel),
    .y        (comb_res),
    .dly_next (dly_new)
  );

`ifdef CIC_DECIM_ROUND_EN
  localparam int unsigned WP = W + 1;
  localparam logic [W:0] Half = WP'(1) << (W - OUT_W - 1);
  logic [W:0]         rounded;
  logic [W-OUT_W-1:0] unused_round;
  assign rounded      = {comb_res[W-1], comb_res} + Half;
  assign unused_round = rounded[W-OUT_W-1:0];
  // A positive half-LSB can only overflow upward.
  assign out_slice    = (rounded[W] != rounded[W-1]) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                     : rounded[W-1 -: OUT_W];
`else
  logic [W-OUT_W-1:0] unused_lsb;
  assign unused_lsb = comb_res[W-OUT_W-1:0];
  assign out_slice  = comb_res[W-1 -: OUT_W];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integ_q       <= '{default: '0};
      dly_q         <= '{default: '0};
      phase_q       <= '{default: '0};
      err_q         <= '{default: '0};
      exp_ch_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_error_q   <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      if (beat) begin
        for (int k = 0; k < STAGES; k++) integ_q[ch][k] <= integ_new[k];
        phase_q[ch] <= dump ? '0 : phase_q[ch] + PH_W'(1);
        exp_ch_q    <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);
        err_q[ch]   <= dump ? 2'b00 : (err_q[ch] | bus.in_error);
      end else if (accept) begin
        err_q[exp_ch_q][ErrSequence] <= 1'b1;
      end
      if (dump) begin
        for (int i = 0; i < DLY_N; i++) dly_q[ch][i] <= dly_new[i];
        out_valid_q   <= 1'b1;
        out_data_q    <= out_slice;
        out_channel_q <= ch;
        out_error_q   <= err_q[ch] | bus.in_error;
        out_sop_q     <= (ch == '0);
        out_eop_q     <= (ch == CH_W'(CHANNELS - 1));
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_channel       = out_channel_q;
  assign bus.out_error         = out_error_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
endmodule

// File: tb/tb_cic_decim.sv
// Directed self-checking bench for cic_decim at default parameters (N=4, R=125, M=1, 2 channels).
module tb_cic_decim;
  import cic_decim_pkg::*;

  localparam int unsigned IN_W = 16, OUT_W = 16, STAGES = 4, RATE = 125, DIFF_DELAY = 1;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CH_W = 1;
  // 125**4 = 244140625 < 2**28, so W = 44 and the output keeps bits [43:28].
  localparam int unsigned SHIFT = 28;
  localparam int DcCh0 = 14901;
`ifdef CIC_DECIM_ROUND_EN
  localparam int DcCh1 = -29802;
`else
  localparam int DcCh1 = -29803;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cic_decim_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CH_W(CH_W)) bus ();

  cic_decim #(
    .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATE(RATE), .DIFF_DELAY(DIFF_DELAY),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0, n_bad = 0, timeouts = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Output capture.
  int got_data[$], got_ch[$], got_err[$], got_sop[$], got_eop[$];
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      got_data.push_back(int'($signed(bus.out_data)));
      got_ch.push_back(int'(bus.out_channel));
      got_err.push_back(int'(bus.out_error));
      got_sop.push_back(int'(bus.out_startofpacket));
      got_eop.push_back(int'(bus.out_endofpacket));
    end
  end

  // Reference CIC in wide integers with no wraparound.
  longint m_integ [CHANNELS][STAGES];
  longint m_dly   [CHANNELS][STAGES][DIFF_DELAY];
  int     m_phase [CHANNELS];
  int     exp_data[$], exp_ch[$];

  function automatic int scale(input longint v);
`ifdef CIC_DECIM_ROUND_EN
    v = v + (longint'(1) << (SHIFT - 1));
`endif
    v = v >>> SHIFT;
    if (v > 32767) v = 32767;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_phase[c] = 0;
      for (int s = 0; s < STAGES; s++) begin
        m_integ[c][s] = 0;
        for (int j = 0; j < DIFF_DELAY; j++) m_dly[c][s][j] = 0;
      end
    end
    exp_data.delete();
    exp_ch.delete();
  endtask

  task automatic model_beat(input int c, input int d);
    longint x, y;
    m_integ[c][0] += longint'(d);
    for (int k = 1; k < STAGES; k++) m_integ[c][k] += m_integ[c][k-1];
    m_phase[c]++;
    if (m_phase[c] == RATE) begin
      m_phase[c] = 0;
      x = m_integ[c][STAGES-1];
      for (int s = 0; s < STAGES; s++) begin
        y = x - m_dly[c][s][DIFF_DELAY-1];
        for (int j = DIFF_DELAY - 1; j > 0; j--) m_dly[c][s][j] = m_dly[c][s][j-1];
        m_dly[c][s][0] = x;
        x = y;
      end
      exp_data.push_back(scale(x));
      exp_ch.push_back(c);
    end
  endtask

  // Presents one beat and returns at 1 time unit after its accepting edge.
  task automatic send(input int c, input int d, input bit sop, input bit [1:0] err, input bit mdl);
    bit done = 1'b0;
    bus.in_valid         = 1'b1;
    bus.in_channel       = CH_W'(c);
    bus.in_data          = IN_W'(d);
    bus.in_startofpacket = sop;
    bus.in_endofpacket   = (c == CHANNELS - 1);
    bus.in_error         = err;
    for (int g = 0; g < 1000 && !done; g++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) timeouts++;
    else if (mdl) model_beat(c, d);
    bus.in_valid         = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_error         = 2'b00;
  endtask

  task automatic clear_capture();
    got_data.delete(); got_ch.delete(); got_err.delete(); got_sop.delete(); got_eop.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_capture();
    model_reset();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, longint'(bus.out_valid), 0);
    check({pfx, "_data"}, longint'(bus.out_data), 0);
    check({pfx, "_channel"}, longint'(bus.out_channel), 0);
    check({pfx, "_error"}, longint'(bus.out_error), 0);
    check({pfx, "_sop"}, longint'(bus.out_startofpacket), 0);
    check({pfx, "_eop"}, longint'(bus.out_endofpacket), 0);
    check({pfx, "_in_ready"}, longint'(bus.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_channel = '0; bus.in_data = '0; bus.in_error = 2'b00;
    bus.in_startofpacket = 1'b0; bus.in_endofpacket = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    #1 check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Stalled output then asynchronous reset while out_valid is held.
    bus.out_ready = 1'b0;
    for (int p = 0; p < 124; p++) begin
      send(0, 1000, 1'b1, 2'b00, 1'b0);
      send(1, 1000, 1'b0, 2'b00, 1'b0);
    end
    check("hold_pre_valid", longint'(bus.out_valid), 0);
    send(0, 1000, 1'b1, 2'b00, 1'b0);
    check("hold_valid", longint'(bus.out_valid), 1);
    check("hold_in_ready", longint'(bus.in_ready), 0);
    check("hold_channel", longint'(bus.out_channel), 0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("arst");
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Partial window of 60 beats per channel, discarded by reset, then DC on both channels.
    for (int p = 0; p < 60; p++) begin
      send(0, 16384, 1'b1, 2'b00, 1'b0);
      send(1, -32768, 1'b0, 2'b00, 1'b0);
    end
    apply_reset();
    for (int p = 0; p < 6 * 125; p++) begin
      send(0, 16384, 1'b1, 2'b00, 1'b1);
      if (p == 123) check("lat_early", longint'(bus.out_valid), 0);
      if (p == 124) check("lat_rise", longint'(bus.out_valid), 1);
      send(1, -32768, 1'b0, 2'b00, 1'b1);
    end
    repeat (4) @(posedge clk);
    check("dc_count", got_data.size(), 12);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check("dc_model", got_data[i], exp_data[i]);
      check("dc_channel", got_ch[i], i % 2);
      check("dc_sop", got_sop[i], (i % 2 == 0) ? 1 : 0);
      check("dc_eop", got_eop[i], (i % 2 == 1) ? 1 : 0);
      if (i >= 8) check("dc_settled", got_data[i], (i % 2 == 0) ? DcCh0 : DcCh1);
    end

    // Ramp stimulus with a 300-cycle output stall mid-stream.
    apply_reset();
    fork
      begin
        for (int p = 0; p < 4 * 125; p++) begin
          send(0, ((p * 37) % 4001) - 2000, 1'b1, 2'b00, 1'b1);
          send(1, 1500 - ((p * 91) % 3001), 1'b0, 2'b00, 1'b1);
        end
      end
      begin
        repeat (200) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("stall_valid", longint'(bus.out_valid), 1);
        check("stall_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    check("bp_count", got_data.size(), exp_data.size());
    check("bp_model_count", exp_data.size(), 8);
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check("bp_data", got_data[i], exp_data[i]);
      check("bp_channel", got_ch[i], exp_ch[i]);
    end

    // Upstream error on one ch0 beat of the second window.
    apply_reset();
    for (int p = 0; p < 3 * 125; p++) begin
      send(0, 100, 1'b1, (p == 135) ? 2'b01 : 2'b00, 1'b0);
      send(1, 100, 1'b0, 2'b00, 1'b0);
    end
    repeat (4) @(posedge clk);
    check("err_count", got_err.size(), 6);
    for (int i = 0; i < got_err.size(); i++) check("err_flags", got_err[i], (i == 2) ? 1 : 0);

    // Channel 1 where 0 is expected, then a resynchronising SOP.
    apply_reset();
    send(0, 100, 1'b1, 2'b00, 1'b0);
    send(1, 100, 1'b0, 2'b00, 1'b0);
    send(1, 100, 1'b0, 2'b00, 1'b0);
    for (int p = 0; p < 124; p++) begin
      send(0, 100, 1'b0, 2'b00, 1'b0);
      send(1, 100, 1'b0, 2'b00, 1'b0);
    end
    repeat (4) @(posedge clk);
    check("seq_count", got_err.size(), 2);
    if (got_err.size() >= 2) begin
      check("seq_ch0_chan", got_ch[0], 0);
      check("seq_ch0_err", got_err[0], 2);
      check("seq_ch1_err", got_err[1], 0);
    end
    clear_capture();
    send(0, 100, 1'b0, 2'b00, 1'b0);
    send(0, 100, 1'b1, 2'b00, 1'b0);
    for (int p = 0; p < 123; p++) begin
      send(1, 100, 1'b0, 2'b00, 1'b0);
      send(0, 100, 1'b0, 2'b00, 1'b0);
    end
    repeat (4) @(posedge clk);
    check("resync_count", got_err.size(), 1);
    if (got_err.size() >= 1) begin
      check("resync_chan", got_ch[0], 0);
      check("resync_err", got_err[0], 0);
    end

    check("timeouts", timeouts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
